// File: rtl/vend_pkg.sv
// Shared vending definitions: coin encoding, coin values and the
// dispenser state encoding. The coin encoding matches the vending FSM
// coin input.
package vend_pkg;

  localparam int NUM_COINS = 4;

  typedef enum logic [1:0] {
    C1  = 2'd0,
    C5  = 2'd1,
    C10 = 2'd2,
    C25 = 2'd3
  } coin_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SELECT  = 3'd1,
    ST_PRESENT = 3'd2,
    ST_DONE    = 3'd3,
    ST_FAULT   = 3'd4
  } disp_state_t;

  // Value in cents of one coin. Eight bits hold the largest coin; users
  // resize to their datapath width (which must be at least 5 bits).
  function automatic logic [7:0] coin_val(input coin_t c);
    logic [7:0] v;
    case (c)
      C1:      v = 8'd1;
      C5:      v = 8'd5;
      C10:     v = 8'd10;
      default: v = 8'd25;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Bus between the vending FSM / coin mechanism (master) and the change
// dispenser (slave).
//
// Handshake: the dispenser presents a coin by raising coin_valid with a
// stable coin_code; the coin mechanism answers with coin_ack. A coin is
// transferred on the clock edge where coin_valid and coin_ack are both
// high; coin_valid then drops for at least one cycle. coin_ack while
// coin_valid is low has no effect. start/refill are single-cycle
// requests that only take effect while busy is low.
interface change_dispenser_if #(
  parameter int WIDTH = 8
);
  import vend_pkg::*;

  logic              start;
  logic [WIDTH-1:0]  amount;
  logic              refill;
  logic              coin_ack;
  logic              coin_valid;
  coin_t             coin_code;
  logic              busy;
  logic              done;
  logic              fault;
  logic [WIDTH-1:0]  remaining;
  logic [WIDTH-1:0]  shortfall;
  logic [WIDTH-1:0]  coins_out;
  logic [3:0]        stock_empty;
  disp_state_t       state;        // debug view of the dispenser FSM

  modport master (
    output start, amount, refill, coin_ack,
    input  coin_valid, coin_code, busy, done, fault,
           remaining, shortfall, coins_out, stock_empty, state
  );

  modport slave (
    input  start, amount, refill, coin_ack,
    output coin_valid, coin_code, busy, done, fault,
           remaining, shortfall, coins_out, stock_empty, state
  );

endinterface

// File: rtl/change_dispenser_coin_select.sv
// Greedy coin picker: highest-value coin that is in stock and does not
// exceed the value still owed.
module coin_select
  import vend_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_remaining,
  input  logic [3:0]       i_stock_empty,
  output logic             o_found,
  output coin_t            o_code
);

  // Scan low to high so the highest eligible code wins.
  always_comb begin
    o_found = 1'b0;
    o_code  = C1;
    for (int i = 0; i < NUM_COINS; i++) begin
      if (!i_stock_empty[i] &&
          (i_remaining >= WIDTH'(coin_val(coin_t'(2'(i)))))) begin
        o_found = 1'b1;
        o_code  = coin_t'(2'(i));
      end
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays an amount out as single-coin requests, largest
// coin first, tracking per-denomination stock and flagging shortfalls.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int STOCK_W    = 4,
  parameter int INIT_STOCK = 15
) (
  input  logic                clk,
  input  logic                rst,
  change_dispenser_if.slave   bus
);

  localparam logic [STOCK_W-1:0] INIT_S = STOCK_W'(INIT_STOCK);

  disp_state_t        r_state;
  disp_state_t        w_next;
  logic [WIDTH-1:0]   r_remaining;
  logic [WIDTH-1:0]   r_shortfall;
  logic [WIDTH-1:0]   r_coins_out;
  coin_t              r_code;
  logic [STOCK_W-1:0] r_stock [NUM_COINS];

  logic               w_found;
  coin_t              w_code;
  logic [3:0]         w_stock_empty;
  logic [WIDTH-1:0]   w_coin_val;

  // Empty flags per denomination, fed to the picker and the bus.
  always_comb begin
    w_stock_empty = '0;
    for (int i = 0; i < NUM_COINS; i++) begin
      w_stock_empty[i] = (r_stock[i] == '0);
    end
  end

  assign w_coin_val = WIDTH'(coin_val(r_code));

  coin_select #(.WIDTH(WIDTH)) u_coin_select (
    .i_remaining   (r_remaining),
    .i_stock_empty (w_stock_empty),
    .o_found       (w_found),
    .o_code        (w_code)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) w_next = (bus.amount != '0) ? ST_SELECT : ST_DONE;
      end
      ST_SELECT: begin
        if (w_found)                 w_next = ST_PRESENT;
        else if (r_remaining == '0)  w_next = ST_DONE;
        else                         w_next = ST_FAULT;
      end
      ST_PRESENT: begin
        if (bus.coin_ack) w_next = ST_SELECT;
      end
      ST_DONE:  w_next = ST_IDLE;
      ST_FAULT: w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // FSM-decoded outputs; coin_valid is exactly the PRESENT state.
  always_comb begin
    bus.coin_valid = (r_state == ST_PRESENT);
    bus.done       = (r_state == ST_DONE);
    bus.fault      = (r_state == ST_FAULT);
    bus.busy       = (r_state != ST_IDLE);
  end

  // Datapath: amount owed, coin selection, counters and stock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_remaining <= '0;
      r_shortfall <= '0;
      r_coins_out <= '0;
      r_code      <= C1;
      for (int i = 0; i < NUM_COINS; i++) r_stock[i] <= INIT_S;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            // A zero amount loads zero, so remaining is consistent either way.
            r_remaining <= bus.amount;
            r_coins_out <= '0;
            r_shortfall <= '0;
          end else if (bus.refill) begin
            for (int i = 0; i < NUM_COINS; i++) r_stock[i] <= INIT_S;
          end
        end
        ST_SELECT: begin
          if (w_found)                r_code      <= w_code;
          else if (r_remaining != '0) r_shortfall <= r_remaining;
        end
        ST_PRESENT: begin
          if (bus.coin_ack) begin
            // The picker only offers coins <= remaining and in stock,
            // so neither subtraction can wrap.
            r_remaining     <= r_remaining - w_coin_val;
            r_stock[r_code] <= r_stock[r_code] - 1'b1;
            r_coins_out     <= r_coins_out + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Registered values to the bus.
  always_comb begin
    bus.coin_code   = r_code;
    bus.remaining   = r_remaining;
    bus.shortfall   = r_shortfall;
    bus.coins_out   = r_coins_out;
    bus.stock_empty = w_stock_empty;
    bus.state       = r_state;
  end

endmodule
